// File: rtl/id_pkg.sv
// Shared types and constants for the decode-side instruction queue.
// Holds ExcCodes, opcode/func encodings, the queue entry layout and opcode legality.
package id_pkg;

   localparam int PC_MAX_W = 32;

   typedef enum logic [4:0] {
      EX_INT  = 5'h00,
      EX_ADEL = 5'h04,
      EX_ADES = 5'h05,
      EX_SYS  = 5'h08,
      EX_BP   = 5'h09,
      EX_RI   = 5'h0a,
      EX_OV   = 5'h0c,
      EX_ERET = 5'h0d
   } excode_e;

   localparam logic [5:0] OP_SPECIAL   = 6'b000000;
   localparam logic [5:0] OP_REGIMM    = 6'b000001;
   localparam logic [5:0] OP_J         = 6'b000010;
   localparam logic [5:0] OP_JAL       = 6'b000011;
   localparam logic [5:0] OP_COP0      = 6'b010000;
   localparam logic [5:0] FUNC_SYSCALL = 6'b001100;
   localparam logic [5:0] FUNC_BREAK   = 6'b001101;

   localparam logic [31:0] INST_ERET      = 32'h4200_0018;
   localparam logic [31:0] INST_SELF_LOOP = 32'h1000_ffff;

   typedef struct packed {
      logic [31:0]         inst;
      logic [PC_MAX_W-1:0] pc;
      logic                ex;
      logic [4:0]          excode;
   } entry_t;

   // Opcodes implemented by the pipeline; anything else raises RI.
   function automatic logic op_defined(input logic [5:0] op);
      logic ok;
      case (op) inside
         6'b000000, 6'b000001, 6'b000010, 6'b000011,
         6'b0001??, 6'b001???, 6'b010000,
         6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
         6'b101000, 6'b101001, 6'b101011: ok = 1'b1;
         default:                         ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/id_queue_stage_if.sv
// IF->queue and queue->EX handshake bundle; slave is the queue's view, master the surroundings'.
interface id_queue_stage_if #(
   parameter int PC_W = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [PC_W-1:0] in_pc;
   logic            in_ex;
   logic [4:0]      in_excode;

   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_inst;
   logic [PC_W-1:0] out_pc;
   logic [4:0]      out_rs;
   logic [4:0]      out_rt;
   logic [4:0]      out_rd;
   logic            out_ex;
   logic [4:0]      out_excode;
   logic            out_bd;
   logic            out_eret;

   modport slave (
      input  in_valid, in_inst, in_pc, in_ex, in_excode, out_ready,
      output in_ready, out_valid, out_inst, out_pc, out_rs, out_rt, out_rd,
             out_ex, out_excode, out_bd, out_eret
   );

   modport master (
      output in_valid, in_inst, in_pc, in_ex, in_excode, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, out_rs, out_rt, out_rd,
             out_ex, out_excode, out_bd, out_eret
   );
endinterface

// File: rtl/id_fifo.sv
// Circular entry store for the decode queue: storage, wrap-around pointers and occupancy.
// Flush has priority over push/pop; push while full and pop while empty are ignored.
module id_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_wdata,
   output logic [WIDTH-1:0]             o_rdata,
   output logic                         o_empty,
   output logic                         o_full,
   output logic [$clog2(DEPTH+1)-1:0]   o_level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_push, w_pop;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign w_push  = i_push & ~o_full & ~i_flush;
   assign w_pop   = i_pop & ~o_empty & ~i_flush;
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_level = r_level;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and level alone define which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/id_queue_stage.sv
// Decode-side instruction queue between IF and EX: buffers fetched entries, extracts
// register indices, merges exceptions, tracks delay slots and inserts the load-use bubble.
module id_queue_stage
   import id_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   id_queue_stage_if.slave              bus,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int ENTRY_W = $bits(entry_t);

   entry_t     w_push_entry, w_head, w_cur, r_hold;
   logic       w_empty, w_full, w_push, w_pop;
   logic [5:0] w_op, w_func;
   logic [4:0] w_rs, w_rt, w_rd, w_excode, r_ld_rd;
   logic       w_ex, w_eret, w_is_branch, w_hazard, r_bd;

   always_comb begin
      w_push_entry        = '0;
      w_push_entry.inst   = bus.in_inst;
      w_push_entry.pc     = PC_MAX_W'(bus.in_pc);
      w_push_entry.ex     = bus.in_ex;
      w_push_entry.excode = bus.in_excode;
   end

   assign w_push = bus.in_valid & ~w_full;

   id_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_flush (flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_push_entry),
      .o_rdata (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_level (level)
   );

   // While empty the outputs keep showing the last head that was presented.
   assign w_cur  = w_empty ? r_hold : w_head;
   assign w_op   = w_cur.inst[31:26];
   assign w_func = w_cur.inst[5:0];

   assign w_rs = (w_op == OP_J || w_op == OP_JAL) ? 5'd0 : w_cur.inst[25:21];
   assign w_rt = (w_op == OP_REGIMM || w_op == OP_J || w_op == OP_JAL || w_op[5:3] == 3'b100)
                 ? 5'd0 : w_cur.inst[20:16];

   // NOTE: each always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      w_rd = 5'd0;
      if (w_op == OP_SPECIAL)
         w_rd = w_cur.inst[15:11];
      else if (w_op[5:3] == 3'b001 || w_op[5:3] == 3'b100 ||
               (w_op == OP_COP0 && w_cur.inst[25:21] == 5'd0))
         w_rd = w_cur.inst[20:16];
      else if (w_op == OP_REGIMM || w_op == OP_JAL)
         w_rd = 5'd31;
   end

   assign w_eret = (w_cur.inst == INST_ERET);

   always_comb begin
      w_ex     = 1'b1;
      w_excode = EX_INT;
      if (w_cur.ex)                                         w_excode = w_cur.excode;
      else if (w_eret)                                      w_excode = EX_ERET;
      else if (w_cur.inst == INST_SELF_LOOP)                w_excode = EX_INT;
      else if (w_op == OP_SPECIAL && w_func == FUNC_SYSCALL) w_excode = EX_SYS;
      else if (w_op == OP_SPECIAL && w_func == FUNC_BREAK)  w_excode = EX_BP;
      else if (!op_defined(w_op))                           w_excode = EX_RI;
      else                                                  w_ex     = 1'b0;
   end

   assign w_is_branch = (w_op == OP_REGIMM) || (w_op == OP_J) || (w_op == OP_JAL) ||
                        (w_op[5:2] == 4'b0001) ||
                        (w_op == OP_SPECIAL && w_func[5:1] == 5'b00100);

   assign w_hazard = (r_ld_rd != 5'd0) && ((w_rs == r_ld_rd) || (w_rt == r_ld_rd));

   assign bus.in_ready   = ~w_full;
   assign bus.out_valid  = ~w_empty & ~w_hazard & ~flush;
   assign w_pop          = bus.out_valid & bus.out_ready;
   assign bus.out_inst   = w_cur.inst[INST_W-1:0];
   assign bus.out_pc     = w_cur.pc[PC_W-1:0];
   assign bus.out_rs     = w_rs;
   assign bus.out_rt     = w_rt;
   assign bus.out_rd     = w_rd;
   assign bus.out_ex     = w_ex;
   assign bus.out_excode = w_excode;
   assign bus.out_bd     = r_bd;
   assign bus.out_eret   = w_eret;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hold  <= '0;
         r_bd    <= 1'b0;
         r_ld_rd <= 5'd0;
      end else begin
         if (!w_empty) r_hold <= w_head;
         if (flush) begin
            r_bd    <= 1'b0;
            r_ld_rd <= 5'd0;
         end else begin
            if (w_pop) r_bd <= w_is_branch;
            r_ld_rd <= (w_pop && w_op[5:3] == 3'b100) ? w_rd : 5'd0;
         end
      end
   end

endmodule

// File: tb/tb_id_queue_stage.sv
// Directed self-checking bench for id_queue_stage: ordering, wrap, load-use, delay slot,
// exception merge, flush and asynchronous reset.
module tb_id_queue_stage;
   logic       clk = 1'b0;
   logic       resetn;
   logic       flush;
   logic [2:0] level;
   int         n_tests = 0;
   int         n_fail  = 0;

   id_queue_stage_if #(.PC_W(32)) bus ();

   id_queue_stage #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .bus    (bus),
      .level  (level)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] LW_5_1   = 32'h8C25_0000;
   localparam logic [31:0] ADDU_352 = 32'h00A2_1821;
   localparam logic [31:0] BEQ_12   = 32'h1022_0003;
   localparam logic [31:0] ADDIU_4  = 32'h2484_0001;

   function automatic logic [31:0] mk_addu(input logic [4:0] rd);
      return {6'b000000, 5'd1, 5'd2, rd, 5'd0, 6'b100001};
   endfunction

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ex, input logic [4:0] code, input logic rdy);
      bus.in_valid  = v;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.in_ex     = ex;
      bus.in_excode = code;
      bus.out_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      flush  = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #3;
      n_tests++; if (level !== 3'd0) begin $display("FAIL reset_level got %0d exp 0", level); n_fail++; end
      n_tests++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); n_fail++; end
      n_tests++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); n_fail++; end
      n_tests++; if (bus.out_inst !== 32'h0 || bus.out_pc !== 32'h0) begin
         $display("FAIL reset_data got inst %h pc %h exp 0/0", bus.out_inst, bus.out_pc); n_fail++; end
      n_tests++; if (bus.out_bd !== 1'b0 || bus.out_ex !== 1'b0 || bus.out_rd !== 5'd0) begin
         $display("FAIL reset_flags got bd %b ex %b rd %0d exp 0/0/0", bus.out_bd, bus.out_ex, bus.out_rd); n_fail++; end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, mk_addu(5'(i + 3)), 32'h100 + 32'(4 * i), 1'b0, 5'd0, 1'b0);
         step();
      end
      drive(1'b1, 32'h0000_1821, 32'h200, 1'b0, 5'd0, 1'b0);
      #1;
      n_tests++; if (level !== 3'd4 || bus.in_ready !== 1'b0) begin
         $display("FAIL full got level %0d in_ready %b exp 4/0", level, bus.in_ready); n_fail++; end
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (level !== 3'd4) begin $display("FAIL fifth_push_ignored got level %0d exp 4", level); n_fail++; end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_inst !== mk_addu(5'(i + 3)) ||
             bus.out_pc !== 32'h100 + 32'(4 * i) || bus.out_rd !== 5'(i + 3)) begin
            $display("FAIL drain_%0d got v %b inst %h pc %h rd %0d exp 1/%h/%h/%0d", i, bus.out_valid,
                     bus.out_inst, bus.out_pc, bus.out_rd, mk_addu(5'(i + 3)), 32'h100 + 32'(4 * i), i + 3);
            n_fail++;
         end
         step();
         #1;
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      n_tests++; if (bus.out_valid !== 1'b0 || level !== 3'd0 || bus.out_inst !== mk_addu(5'd6)) begin
         $display("FAIL empty_hold got v %b level %0d inst %h exp 0/0/%h", bus.out_valid, level,
                  bus.out_inst, mk_addu(5'd6)); n_fail++; end
      step();
   endtask

   task automatic test_push_pop_wrap();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, mk_addu(5'(10 + k)), 32'h300 + 32'(4 * k), 1'b0, 5'd0, 1'b0);
         step();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, mk_addu(5'(12 + k)), 32'h308 + 32'(4 * k), 1'b0, 5'd0, 1'b1);
         #1;
         n_tests++;
         if (level !== 3'd2 || bus.out_valid !== 1'b1 || bus.out_inst !== mk_addu(5'(10 + k))) begin
            $display("FAIL wrap_pp_%0d got level %0d v %b inst %h exp 2/1/%h", k, level,
                     bus.out_valid, bus.out_inst, mk_addu(5'(10 + k))); n_fail++; end
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_tests++;
         if (level !== 3'(2 - k) || bus.out_inst !== mk_addu(5'(14 + k))) begin
            $display("FAIL wrap_tail_%0d got level %0d inst %h exp %0d/%h", k, level, bus.out_inst,
                     2 - k, mk_addu(5'(14 + k))); n_fail++; end
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic test_load_use();
      drive(1'b1, LW_5_1, 32'h400, 1'b0, 5'd0, 1'b1);
      step();
      drive(1'b1, ADDU_352, 32'h404, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_inst !== LW_5_1 ||
                     bus.out_rs !== 5'd1 || bus.out_rt !== 5'd0 || bus.out_rd !== 5'd5) begin
         $display("FAIL lw_issue got v %b inst %h rs %0d rt %0d rd %0d exp 1/%h/1/0/5", bus.out_valid,
                  bus.out_inst, bus.out_rs, bus.out_rt, bus.out_rd, LW_5_1); n_fail++; end
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (bus.out_valid !== 1'b0 || bus.out_inst !== ADDU_352) begin
         $display("FAIL load_use_bubble got v %b inst %h exp 0/%h", bus.out_valid, bus.out_inst, ADDU_352); n_fail++; end
      step();
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_inst !== ADDU_352 || bus.out_rs !== 5'd5 ||
                     bus.out_rt !== 5'd2 || bus.out_rd !== 5'd3) begin
         $display("FAIL addu_after_bubble got v %b inst %h rs %0d rt %0d rd %0d exp 1/%h/5/2/3",
                  bus.out_valid, bus.out_inst, bus.out_rs, bus.out_rt, bus.out_rd, ADDU_352); n_fail++; end
      step();
      n_tests++; if (level !== 3'd0) begin $display("FAIL load_use_drained got level %0d exp 0", level); n_fail++; end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic test_branch_delay();
      drive(1'b1, BEQ_12, 32'h500, 1'b0, 5'd0, 1'b1);
      step();
      drive(1'b1, ADDIU_4, 32'h504, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (bus.out_inst !== BEQ_12 || bus.out_bd !== 1'b0) begin
         $display("FAIL beq_bd got inst %h bd %b exp %h/0", bus.out_inst, bus.out_bd, BEQ_12); n_fail++; end
      step();
      drive(1'b1, mk_addu(5'd7), 32'h508, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (bus.out_inst !== ADDIU_4 || bus.out_bd !== 1'b1 || bus.out_rt !== 5'd4 || bus.out_rd !== 5'd4) begin
         $display("FAIL delay_slot_bd got inst %h bd %b rt %0d rd %0d exp %h/1/4/4", bus.out_inst,
                  bus.out_bd, bus.out_rt, bus.out_rd, ADDIU_4); n_fail++; end
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (bus.out_inst !== mk_addu(5'd7) || bus.out_bd !== 1'b0) begin
         $display("FAIL after_slot_bd got inst %h bd %b exp %h/0", bus.out_inst, bus.out_bd, mk_addu(5'd7)); n_fail++; end
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   typedef struct {
      logic [31:0] inst;
      logic        in_ex;
      logic [4:0]  in_code;
      logic        exp_ex;
      logic [4:0]  exp_code;
      logic        exp_eret;
   } exc_vec_t;

   task automatic test_exceptions();
      exc_vec_t vec [8];
      vec[0] = '{32'h0000_000C, 1'b1, 5'h04, 1'b1, 5'h04, 1'b0};
      vec[1] = '{32'h0000_000C, 1'b0, 5'h00, 1'b1, 5'h08, 1'b0};
      vec[2] = '{32'h0000_000D, 1'b0, 5'h00, 1'b1, 5'h09, 1'b0};
      vec[3] = '{32'h4200_0018, 1'b0, 5'h00, 1'b1, 5'h0d, 1'b1};
      vec[4] = '{32'h1000_FFFF, 1'b0, 5'h00, 1'b1, 5'h00, 1'b0};
      vec[5] = '{32'hFC00_0000, 1'b0, 5'h00, 1'b1, 5'h0a, 1'b0};
      vec[6] = '{32'h0022_1821, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0};
      vec[7] = '{32'h4200_0018, 1'b1, 5'h04, 1'b1, 5'h04, 1'b1};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vec[i].inst, 32'h600 + 32'(4 * i), vec[i].in_ex, vec[i].in_code, 1'b0);
         step();
         drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
         #1;
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_ex !== vec[i].exp_ex ||
             bus.out_excode !== vec[i].exp_code || bus.out_eret !== vec[i].exp_eret) begin
            $display("FAIL exc_%0d inst %h got v %b ex %b code %h eret %b exp 1/%b/%h/%b", i, vec[i].inst,
                     bus.out_valid, bus.out_ex, bus.out_excode, bus.out_eret,
                     vec[i].exp_ex, vec[i].exp_code, vec[i].exp_eret);
            n_fail++;
         end
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic test_flush();
      drive(1'b1, BEQ_12, 32'h700, 1'b0, 5'd0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk_addu(5'(20 + i)), 32'h704 + 32'(4 * i), 1'b0, 5'd0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (bus.out_inst !== BEQ_12 || level !== 3'd4) begin
         $display("FAIL flush_pre got inst %h level %0d exp %h/4", bus.out_inst, level, BEQ_12); n_fail++; end
      step();
      drive(1'b1, mk_addu(5'd30), 32'h780, 1'b0, 5'd0, 1'b1);
      flush = 1'b1;
      #1;
      n_tests++; if (level !== 3'd3 || bus.out_valid !== 1'b0 || bus.out_bd !== 1'b1) begin
         $display("FAIL flush_cycle got level %0d v %b bd %b exp 3/0/1", level, bus.out_valid, bus.out_bd); n_fail++; end
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      n_tests++; if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_bd !== 1'b0 || bus.in_ready !== 1'b1) begin
         $display("FAIL flush_after got level %0d v %b bd %b rdy %b exp 0/0/0/1", level, bus.out_valid,
                  bus.out_bd, bus.in_ready); n_fail++; end
      step();
      drive(1'b1, mk_addu(5'd31), 32'h790, 1'b0, 5'd0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      #1;
      n_tests++; if (level !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_inst !== mk_addu(5'd31) || bus.out_bd !== 1'b0) begin
         $display("FAIL flush_restart got level %0d v %b inst %h bd %b exp 1/1/%h/0", level, bus.out_valid,
                  bus.out_inst, bus.out_bd, mk_addu(5'd31)); n_fail++; end
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic test_reset_mid();
      drive(1'b1, mk_addu(5'd9), 32'h800, 1'b0, 5'd0, 1'b0);
      step();
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      n_tests++; if (level !== 3'd2) begin $display("FAIL mid_reset_pre got level %0d exp 2", level); n_fail++; end
      #2 resetn = 1'b0;
      #1;
      n_tests++; if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inst !== 32'h0) begin
         $display("FAIL mid_reset got level %0d v %b rdy %b inst %h exp 0/0/1/0", level, bus.out_valid,
                  bus.in_ready, bus.out_inst); n_fail++; end
      #1 resetn = 1'b1;
      step();
      n_tests++; if (level !== 3'd0 || bus.out_valid !== 1'b0) begin
         $display("FAIL post_reset got level %0d v %b exp 0/0", level, bus.out_valid); n_fail++; end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_push_pop_wrap();
      test_load_use();
      test_branch_delay();
      test_exceptions();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "timeout");
   end

endmodule
